// File: rtl/elec_readback_deserializer_pkg.sv
// elec_readback_deserializer_pkg: shared frame geometry and main-FSM shift-state encodings
package elec_readback_deserializer_pkg;
  localparam int SPI_ADDR_LEN = 6;
  localparam int SPI_DATA_LEN = 16;
  localparam int FRAME_BITS = (2**SPI_ADDR_LEN)*SPI_DATA_LEN;
  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam logic [3:0] ST_IDLE = 4'b0000;
  localparam logic [3:0] ST_SHIFT_A = 4'b0010;
  localparam logic [3:0] ST_SHIFT_B = 4'b0100;
  typedef enum logic [1:0] {PH_IDLE, PH_CAPTURE, PH_COMMIT} phase_t;
  function automatic logic is_shift(input logic [3:0] st);
    return st == ST_SHIFT_A || st == ST_SHIFT_B;
  endfunction
endpackage

// File: rtl/elec_readback_deserializer_if.sv
// elec_readback_deserializer_if: word read port between the SPI slave and the readback shadow
interface elec_readback_deserializer_if;
  import elec_readback_deserializer_pkg::*;
  logic rd_en;
  logic [SPI_ADDR_LEN-1:0] rd_addr;
  logic [SPI_DATA_LEN-1:0] rd_data;
  logic rd_valid;
  modport master (output rd_en, rd_addr, input rd_data, rd_valid);
  modport slave (input rd_en, rd_addr, output rd_data, rd_valid);
endinterface

// File: rtl/elec_readback_deserializer_readback_word_mux.sv
// readback_word_mux: combinational word select from the shadow frame, zero for unmapped addresses
module readback_word_mux
  import elec_readback_deserializer_pkg::*;
#(
  parameter int ADDR_W = SPI_ADDR_LEN,
  parameter int DATA_W = SPI_DATA_LEN,
  parameter int BITS = FRAME_BITS
) (
  input  logic [BITS-1:0]   shadow,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] word
);
  localparam int WORDS = BITS/DATA_W;
  always_comb word = (32'(addr) < 32'(WORDS)) ? shadow[addr*DATA_W +: DATA_W] : '0;
endmodule

// File: rtl/elec_readback_deserializer.sv
// elec_readback_deserializer: captures the LSB-first electrode readback frame and serves it as SPI words
module elec_readback_deserializer
  import elec_readback_deserializer_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [3:0]                     state,
  input  logic                           serial_in,
  elec_readback_deserializer_if.slave    rd,
  output logic                           frame_done,
  output logic                           frame_ovf,
  output logic                           busy
);
  logic [FRAME_BITS-1:0] shift_reg, shadow, shift_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [SPI_DATA_LEN-1:0] word;
  logic cap_en, commit, unread;
  phase_t phase;
  assign cap_en = is_shift(state);
  assign shift_nxt = {serial_in, shift_reg[FRAME_BITS-1:1]};
  always_comb phase = (cap_en && bit_cnt == CNT_W'(FRAME_BITS-1)) ? PH_COMMIT :
                      (bit_cnt == '0) ? PH_IDLE : PH_CAPTURE;
  assign commit = phase == PH_COMMIT;
  assign busy = bit_cnt != '0;
  readback_word_mux u_mux (.shadow(shadow), .addr(rd.rd_addr), .word(word));
  // shadow takes the incoming bit directly so the committed frame has no one-cycle lag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      shadow <= '0;
      bit_cnt <= '0;
      rd.rd_data <= '0;
      rd.rd_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_ovf <= 1'b0;
      unread <= 1'b0;
    end else begin
      if (cap_en) begin
        shift_reg <= shift_nxt;
        bit_cnt <= bit_cnt + 1'b1;
      end else if (state == ST_IDLE) bit_cnt <= '0;
      if (commit) shadow <= shift_nxt;
      frame_done <= commit;
      frame_ovf <= (state == ST_IDLE) ? 1'b0 : frame_ovf | (commit & unread);
      unread <= commit | (unread & ~rd.rd_en);
      rd.rd_valid <= rd.rd_en;
      if (rd.rd_en) rd.rd_data <= word;
    end
  end
endmodule

// File: tb/tb_elec_readback_deserializer.sv
// tb_elec_readback_deserializer: directed self-checking bench for the readback deserializer
module tb_elec_readback_deserializer;
  import elec_readback_deserializer_pkg::*;
  localparam logic [3:0] ST_HOLD = 4'b1000;
  logic clk = 1'b0, rst_n = 1'b1, serial_in = 1'b0;
  logic [3:0] state = ST_IDLE;
  logic frame_done, frame_ovf, busy;
  int checks = 0, errors = 0, done_cnt = 0, d0;
  logic [FRAME_BITS-1:0] fa, fb, fc, fd;
  elec_readback_deserializer_if rd_if();
  elec_readback_deserializer dut (
    .clk(clk), .rst_n(rst_n), .state(state), .serial_in(serial_in), .rd(rd_if.slave),
    .frame_done(frame_done), .frame_ovf(frame_ovf), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (frame_done) done_cnt++;
  function automatic logic [FRAME_BITS-1:0] mk(input logic [15:0] base, input logic [15:0] step);
    logic [FRAME_BITS-1:0] f;
    for (int n = 0; n < FRAME_BITS/SPI_DATA_LEN; n++) f[n*16 +: 16] = base + 16'(n)*step;
    return f;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic shift(input logic [FRAME_BITS-1:0] f, input int from, input int to, input logic [3:0] st);
    for (int k = from; k < to; k++) begin
      @(negedge clk);
      state = st;
      serial_in = f[k];
    end
  endtask
  task automatic idle(input int n, input logic [3:0] st);
    repeat (n) begin
      @(negedge clk);
      state = st;
    end
  endtask
  task automatic commit_chk(input string tag, input int base, input int exp_done);
    @(negedge clk);
    state = ST_HOLD;
    chk({tag, " frame_done"}, frame_done, 1);
    chk({tag, " busy after commit"}, busy, 0);
    @(negedge clk);
    chk({tag, " frame_done drop"}, frame_done, 0);
    chk({tag, " frame_done count"}, done_cnt - base, exp_done);
  endtask
  task automatic read_word(input int a, input logic [15:0] exp);
    @(negedge clk);
    rd_if.rd_en = 1'b1;
    rd_if.rd_addr = 6'(a);
    @(negedge clk);
    rd_if.rd_en = 1'b0;
    chk($sformatf("rd_valid[%0d]", a), rd_if.rd_valid, 1);
    chk($sformatf("rd_data[%0d]", a), rd_if.rd_data, exp);
  endtask
  task automatic read_all(input logic [FRAME_BITS-1:0] f);
    for (int n = 0; n < FRAME_BITS/SPI_DATA_LEN; n++) read_word(n, f[n*16 +: 16]);
  endtask
  initial begin
    rd_if.rd_en = 1'b0;
    rd_if.rd_addr = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset rd_data", rd_if.rd_data, 0);
    chk("reset rd_valid", rd_if.rd_valid, 0);
    chk("reset frame_done", frame_done, 0);
    chk("reset frame_ovf", frame_ovf, 0);
    chk("reset busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // loopback of the cache pattern
    fa = mk(16'hA500, 16'd1);
    d0 = done_cnt;
    shift(fa, 0, 1023, ST_SHIFT_A);
    @(negedge clk);
    chk("loop busy at bit 1023", busy, 1);
    chk("loop no early done", frame_done, 0);
    serial_in = fa[1023];
    commit_chk("loop", d0, 1);
    read_all(fa);
    @(negedge clk);
    chk("rd_valid idle", rd_if.rd_valid, 0);
    chk("rd_data hold", rd_if.rd_data, 16'hA53F);
    // pause in a non-shift state, resume in the other shift state
    fb = mk(16'h5555, 16'd0);
    d0 = done_cnt;
    shift(fb, 0, 500, ST_SHIFT_A);
    idle(20, ST_HOLD);
    chk("pause busy", busy, 1);
    chk("pause no done", done_cnt - d0, 0);
    shift(fb, 500, 1024, ST_SHIFT_B);
    commit_chk("pause", d0, 1);
    read_all(fb);
    // abort a partial frame
    shift(mk(16'h0000, 16'd0), 0, 300, ST_SHIFT_A);
    idle(1, ST_IDLE);
    idle(1, ST_HOLD);
    chk("abort busy", busy, 0);
    read_word(3, 16'h5555);
    fc = mk(16'hFFFF, 16'd0);
    d0 = done_cnt;
    shift(fc, 0, 1024, ST_SHIFT_A);
    commit_chk("abort", d0, 1);
    read_all(fc);
    chk("no ovf yet", frame_ovf, 0);
    // two back-to-back frames with no read in between
    fc = mk(16'h1200, 16'd3);
    fd = mk(16'hE001, 16'h0101);
    d0 = done_cnt;
    shift(fc, 0, 1024, ST_SHIFT_A);
    shift(fd, 0, 1024, ST_SHIFT_B);
    commit_chk("b2b", d0, 2);
    chk("ovf set", frame_ovf, 1);
    read_all(fd);
    chk("ovf sticky", frame_ovf, 1);
    idle(1, ST_IDLE);
    idle(1, ST_HOLD);
    chk("ovf cleared", frame_ovf, 0);
    // read on the commit edge returns the previous frame
    fc = mk(16'hC000, 16'd1);
    fd = mk(16'hD000, 16'd1);
    d0 = done_cnt;
    shift(fc, 0, 1024, ST_SHIFT_A);
    commit_chk("coll f1", d0, 1);
    read_word(0, 16'hC000);
    shift(fd, 0, 1023, ST_SHIFT_A);
    @(negedge clk);
    serial_in = fd[1023];
    rd_if.rd_en = 1'b1;
    rd_if.rd_addr = 6'd5;
    @(negedge clk);
    state = ST_HOLD;
    rd_if.rd_en = 1'b0;
    chk("coll rd_valid", rd_if.rd_valid, 1);
    chk("coll old word", rd_if.rd_data, 16'hC005);
    chk("coll frame_done", frame_done, 1);
    read_word(5, 16'hD005);
    chk("coll no ovf", frame_ovf, 0);
    // asynchronous reset mid-capture
    fc = mk(16'h3C00, 16'd7);
    shift(fc, 0, 700, ST_SHIFT_A);
    @(posedge clk);
    #2;
    chk("pre-reset busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async rst rd_data", rd_if.rd_data, 0);
    chk("async rst rd_valid", rd_if.rd_valid, 0);
    chk("async rst frame_done", frame_done, 0);
    chk("async rst frame_ovf", frame_ovf, 0);
    chk("async rst busy", busy, 0);
    state = ST_IDLE;
    @(negedge clk);
    rst_n = 1'b1;
    read_word(7, 16'h0000);
    d0 = done_cnt;
    shift(fc, 0, 1024, ST_SHIFT_A);
    commit_chk("post-reset", d0, 1);
    read_all(fc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
